// File: rtl/timer_irq_ctrl_pkg.sv
// Shared types and constants for the timer interrupt controller.
package timer_irq_ctrl_pkg;

    localparam int unsigned MAX_SRC = 32;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_CLAIMED = 2'd2
    } irq_state_e;

    // Width of a source id; a single source still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Core-side claim/complete handshake of the timer interrupt controller.
interface timer_irq_ctrl_if #(
    parameter int unsigned ID_W = 3
);
    logic            irq_o;
    logic            claim_req;
    logic            claim_ack;
    logic            claim_valid;
    logic [ID_W-1:0] claim_id;
    logic            complete_valid;
    logic [ID_W-1:0] complete_id;

    modport master (
        input  irq_o, claim_ack, claim_valid, claim_id,
        output claim_req, complete_valid, complete_id
    );

    modport slave (
        output irq_o, claim_ack, claim_valid, claim_id,
        input  claim_req, complete_valid, complete_id
    );
endinterface

// File: rtl/timer_irq_ctrl_edge_latch.sv
// Per-source rise detector feeding a sticky pending bit; a rise beats a clear.
module irq_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic src_i,
    input  logic clr_i,
    output logic pending_o
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic pend_q, pend_d;

    always_comb begin
        prev_d = src_i;
        rise_d = src_i & ~prev_q;
        pend_d = rise_q | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: sticky pending per source, enable mask, lowest-index
// priority and a single irq line with claim/complete handshake to the core.
module timer_irq_ctrl
    import timer_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_we,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    output logic [NUM_SRC-1:0] enable_o,
    output logic [NUM_SRC-1:0] pending_o,
    timer_irq_ctrl_if.slave    core_if
);

    localparam int unsigned ID_W = id_width(NUM_SRC);

    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] active_c;
    logic [NUM_SRC-1:0] clr_c;
    logic               any_c;
    logic [ID_W-1:0]    sel_c;

    irq_state_e         state_q, state_d;
    logic               claim_fire_c;
    logic               complete_hit_c;

    logic               irq_q, irq_d;
    logic               ack_q, ack_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    claimed_id_q, claimed_id_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_edge_latch u_latch (
            .clk       (clk),
            .rst_n     (rst_n),
            .src_i     (irq_src[g]),
            .clr_i     (clr_c[g]),
            .pending_o (pending[g])
        );
    end

    // Lowest pending-and-enabled index wins.
    always_comb begin
        active_c = pending & enable_q;
        any_c    = |active_c;
        sel_c    = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (active_c[i]) begin
                sel_c = ID_W'(i);
            end
        end
    end

    always_comb begin
        enable_d = cfg_we ? cfg_wdata : enable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A matching completion retires the claim before any same-cycle claim is looked at.
    always_comb begin
        state_d        = state_q;
        claim_fire_c   = 1'b0;
        complete_hit_c = core_if.complete_valid && (core_if.complete_id == claimed_id_q);
        case (state_q)
            IRQ_IDLE: begin
                if (any_c) begin
                    state_d = IRQ_ASSERT;
                end
            end
            IRQ_ASSERT: begin
                if (core_if.claim_req && any_c) begin
                    state_d      = IRQ_CLAIMED;
                    claim_fire_c = 1'b1;
                end else if (!any_c) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_CLAIMED: begin
                if (complete_hit_c) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        irq_d        = (state_d == IRQ_ASSERT);
        ack_d        = core_if.claim_req;
        valid_d      = claim_fire_c;
        id_d         = claim_fire_c ? sel_c : '0;
        claimed_id_d = claim_fire_c ? sel_c : claimed_id_q;
        clr_c        = claim_fire_c ? (NUM_SRC'(1) << sel_c) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q     <= '0;
            irq_q        <= 1'b0;
            ack_q        <= 1'b0;
            valid_q      <= 1'b0;
            id_q         <= '0;
            claimed_id_q <= '0;
        end else begin
            enable_q     <= enable_d;
            irq_q        <= irq_d;
            ack_q        <= ack_d;
            valid_q      <= valid_d;
            id_q         <= id_d;
            claimed_id_q <= claimed_id_d;
        end
    end

    assign enable_o            = enable_q;
    assign pending_o           = pending;
    assign core_if.irq_o       = irq_q;
    assign core_if.claim_ack   = ack_q;
    assign core_if.claim_valid = valid_q;
    assign core_if.claim_id    = id_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with hand-computed expectations.
module tb_timer_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_src;
    logic       cfg_we;
    logic [7:0] cfg_wdata;
    logic [7:0] enable_o;
    logic [7:0] pending_o;
    int         checks = 0;
    int         errors = 0;

    timer_irq_ctrl_if #(.ID_W(3)) core_if ();

    timer_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .enable_o  (enable_o),
        .pending_o (pending_o),
        .core_if   (core_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n                  = 1'b0;
        irq_src                = '0;
        cfg_we                 = 1'b0;
        cfg_wdata              = '0;
        core_if.claim_req      = 1'b0;
        core_if.complete_valid = 1'b0;
        core_if.complete_id    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input logic [7:0] m);
        cfg_we    = 1'b1;
        cfg_wdata = m;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic claim();
        core_if.claim_req = 1'b1;
        tick();
        core_if.claim_req = 1'b0;
    endtask

    task automatic complete(input logic [2:0] id);
        core_if.complete_valid = 1'b1;
        core_if.complete_id    = id;
        tick();
        core_if.complete_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", core_if.irq_o); end
        checks++; if (core_if.claim_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b exp 0", core_if.claim_ack); end
        checks++; if (core_if.claim_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd0) begin errors++; $display("FAIL rst_id: got %0d exp 0", core_if.claim_id); end
        checks++; if (enable_o !== 8'h00) begin errors++; $display("FAIL rst_enable: got %h exp 00", enable_o); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h exp 00", pending_o); end
    endtask

    task automatic test_level();
        do_reset();
        cfg_write(8'h04);
        checks++; if (enable_o !== 8'h04) begin errors++; $display("FAIL lvl_enable: got %h exp 04", enable_o); end
        irq_src = 8'h04;
        tick();
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL lvl_pend_early: got %h exp 00", pending_o); end
        tick();
        checks++; if (pending_o !== 8'h04) begin errors++; $display("FAIL lvl_pend: got %h exp 04", pending_o); end
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL lvl_irq_early: got %b exp 0", core_if.irq_o); end
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL lvl_irq: got %b exp 1", core_if.irq_o); end
        claim();
        checks++; if (core_if.claim_ack !== 1'b1) begin errors++; $display("FAIL lvl_ack: got %b exp 1", core_if.claim_ack); end
        checks++; if (core_if.claim_valid !== 1'b1) begin errors++; $display("FAIL lvl_valid: got %b exp 1", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd2) begin errors++; $display("FAIL lvl_id: got %0d exp 2", core_if.claim_id); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL lvl_pend_clr: got %h exp 00", pending_o); end
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL lvl_irq_claimed: got %b exp 0", core_if.irq_o); end
        tick();
        checks++; if (core_if.claim_ack !== 1'b0) begin errors++; $display("FAIL lvl_ack_pulse: got %b exp 0", core_if.claim_ack); end
        complete(3'd2);
        tick();
        tick();
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL lvl_no_reassert: got %b exp 0", core_if.irq_o); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL lvl_held_pend: got %h exp 00", pending_o); end
        irq_src = 8'h00;
        tick();
        tick();
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL lvl_fall_pend: got %h exp 00", pending_o); end
    endtask

    task automatic test_priority();
        do_reset();
        cfg_write(8'hFF);
        irq_src = 8'h22;
        tick();
        tick();
        checks++; if (pending_o !== 8'h22) begin errors++; $display("FAIL pri_pend: got %h exp 22", pending_o); end
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL pri_irq: got %b exp 1", core_if.irq_o); end
        claim();
        checks++; if (core_if.claim_valid !== 1'b1) begin errors++; $display("FAIL pri_valid1: got %b exp 1", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd1) begin errors++; $display("FAIL pri_id1: got %0d exp 1", core_if.claim_id); end
        checks++; if (pending_o !== 8'h20) begin errors++; $display("FAIL pri_pend1: got %h exp 20", pending_o); end
        complete(3'd1);
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL pri_idle: got %b exp 0", core_if.irq_o); end
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL pri_reassert: got %b exp 1", core_if.irq_o); end
        claim();
        checks++; if (core_if.claim_valid !== 1'b1) begin errors++; $display("FAIL pri_valid5: got %b exp 1", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd5) begin errors++; $display("FAIL pri_id5: got %0d exp 5", core_if.claim_id); end
        complete(3'd5);
        tick();
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL pri_done_irq: got %b exp 0", core_if.irq_o); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL pri_done_pend: got %h exp 00", pending_o); end
        irq_src = 8'h00;
    endtask

    task automatic test_masking();
        do_reset();
        irq_src = 8'h08;
        tick();
        tick();
        tick();
        checks++; if (pending_o !== 8'h08) begin errors++; $display("FAIL msk_pend: got %h exp 08", pending_o); end
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL msk_irq_masked: got %b exp 0", core_if.irq_o); end
        cfg_write(8'h08);
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL msk_irq_1cyc: got %b exp 0", core_if.irq_o); end
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL msk_irq_2cyc: got %b exp 1", core_if.irq_o); end
        cfg_write(8'h00);
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL msk_irq_hold: got %b exp 1", core_if.irq_o); end
        tick();
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL msk_irq_drop: got %b exp 0", core_if.irq_o); end
        checks++; if (pending_o !== 8'h08) begin errors++; $display("FAIL msk_pend_kept: got %h exp 08", pending_o); end
        irq_src = 8'h00;
    endtask

    task automatic test_bad_complete();
        do_reset();
        cfg_write(8'hFF);
        irq_src = 8'h02;
        tick();
        tick();
        tick();
        claim();
        checks++; if (core_if.claim_id !== 3'd1) begin errors++; $display("FAIL bad_id1: got %0d exp 1", core_if.claim_id); end
        irq_src = 8'h06;
        tick();
        tick();
        checks++; if (pending_o !== 8'h04) begin errors++; $display("FAIL bad_pend: got %h exp 04", pending_o); end
        complete(3'd4);
        tick();
        tick();
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL bad_stay_claimed: got %b exp 0", core_if.irq_o); end
        checks++; if (pending_o !== 8'h04) begin errors++; $display("FAIL bad_pend_kept: got %h exp 04", pending_o); end
        complete(3'd1);
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL bad_reassert: got %b exp 1", core_if.irq_o); end
        claim();
        checks++; if (core_if.claim_id !== 3'd2) begin errors++; $display("FAIL bad_id2: got %0d exp 2", core_if.claim_id); end
        complete(3'd2);
        tick();
        claim();
        checks++; if (core_if.claim_ack !== 1'b1) begin errors++; $display("FAIL spur_ack: got %b exp 1", core_if.claim_ack); end
        checks++; if (core_if.claim_valid !== 1'b0) begin errors++; $display("FAIL spur_valid: got %b exp 0", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd0) begin errors++; $display("FAIL spur_id: got %0d exp 0", core_if.claim_id); end
        tick();
        checks++; if (core_if.claim_ack !== 1'b0) begin errors++; $display("FAIL spur_ack_pulse: got %b exp 0", core_if.claim_ack); end
        irq_src = 8'h00;
    endtask

    task automatic test_collision();
        do_reset();
        cfg_write(8'hFF);
        irq_src = 8'h01;
        tick();
        tick();
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL col_irq: got %b exp 1", core_if.irq_o); end
        irq_src = 8'h00;
        tick();
        irq_src = 8'h01;
        tick();
        claim();
        checks++; if (core_if.claim_valid !== 1'b1) begin errors++; $display("FAIL col_valid: got %b exp 1", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd0) begin errors++; $display("FAIL col_id: got %0d exp 0", core_if.claim_id); end
        checks++; if (pending_o !== 8'h01) begin errors++; $display("FAIL col_set_wins: got %h exp 01", pending_o); end
        complete(3'd0);
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL col_reassert: got %b exp 1", core_if.irq_o); end
        irq_src = 8'h00;
    endtask

    task automatic test_async_reset();
        do_reset();
        cfg_write(8'hFF);
        irq_src = 8'h03;
        tick();
        tick();
        tick();
        claim();
        checks++; if (core_if.claim_ack !== 1'b1) begin errors++; $display("FAIL ar_pre_ack: got %b exp 1", core_if.claim_ack); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (core_if.irq_o !== 1'b0) begin errors++; $display("FAIL ar_irq: got %b exp 0", core_if.irq_o); end
        checks++; if (core_if.claim_ack !== 1'b0) begin errors++; $display("FAIL ar_ack: got %b exp 0", core_if.claim_ack); end
        checks++; if (core_if.claim_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b exp 0", core_if.claim_valid); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL ar_pend: got %h exp 00", pending_o); end
        checks++; if (enable_o !== 8'h00) begin errors++; $display("FAIL ar_enable: got %h exp 00", enable_o); end
        irq_src = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (core_if.claim_ack !== 1'b0) begin errors++; $display("FAIL ar_post_ack: got %b exp 0", core_if.claim_ack); end
        cfg_write(8'h01);
        irq_src = 8'h01;
        tick();
        tick();
        tick();
        checks++; if (core_if.irq_o !== 1'b1) begin errors++; $display("FAIL ar_idle_irq: got %b exp 1", core_if.irq_o); end
        claim();
        checks++; if (core_if.claim_valid !== 1'b1) begin errors++; $display("FAIL ar_claim_valid: got %b exp 1", core_if.claim_valid); end
        checks++; if (core_if.claim_id !== 3'd0) begin errors++; $display("FAIL ar_claim_id: got %0d exp 0", core_if.claim_id); end
        irq_src = 8'h00;
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_masking();
        test_bad_complete();
        test_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
